// File: rtl/execute_pipe_if.sv
// Execute-stage port bundle: instruction in from decode, result out to memory stage.
// Latency: none, wires only.
// Backpressure: o_ready travels upstream with the instruction, i_ready downstream with the result.
interface execute_pipe_if #(
  parameter int DATA_W = 32
);
  logic              i_valid;
  logic              o_ready;
  logic [31:0]       i_pc;
  logic [25:0]       i_imm;
  logic [DATA_W-1:0] i_op1;
  logic [DATA_W-1:0] i_op2;
  logic              i_ALUSrc_op2;
  logic              i_extOp;
  logic              i_jump;
  logic              i_beq;
  logic              i_bne;
  logic [5:0]        i_ALUop;
  logic              i_flush;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_ALUres;
  logic [DATA_W-1:0] o_op2;
  logic [31:0]       o_nextPC;
  logic              o_pcsrc;
  logic              o_busy;

  modport master (
    output i_valid, i_pc, i_imm, i_op1, i_op2, i_ALUSrc_op2, i_extOp, i_jump,
           i_beq, i_bne, i_ALUop, i_flush, i_ready,
    input  o_ready, o_valid, o_ALUres, o_op2, o_nextPC, o_pcsrc, o_busy
  );

  modport slave (
    input  i_valid, i_pc, i_imm, i_op1, i_op2, i_ALUSrc_op2, i_extOp, i_jump,
           i_beq, i_bne, i_ALUop, i_flush, i_ready,
    output o_ready, o_valid, o_ALUres, o_op2, o_nextPC, o_pcsrc, o_busy
  );
endinterface

// File: rtl/execute_pipe.sv
// Execute stage: ALU, branch/jump resolution and an optional iterative MUL/DIV unit (EXECUTE_PIPE_MDU_EN).
// Latency: 1 cycle for ALU/branch ops; DATA_W/MDU_ITER + 1 cycles for MULT/DIV.
// Backpressure: result register holds while o_valid && !i_ready; o_ready low while held or MDU busy.
module execute_pipe #(
  parameter int DATA_W   = 32,
  parameter int MDU_ITER = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  execute_pipe_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] F_MFHI   = 6'h10;
  localparam logic [5:0] F_MFLO   = 6'h12;

  if (MDU_ITER != 1 && MDU_ITER != 2 && MDU_ITER != 4) begin : g_bad_iter
    $error("execute_pipe: MDU_ITER must be 1, 2 or 4");
  end

  logic [5:0]        func;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] imm_ext, op_b, alu;
  logic [31:0]       pc4, br_tgt, j_tgt, next_pc;
  logic              zero, pcsrc, accept, is_mdu, mdu_idle, mdu_done;
  logic [DATA_W-1:0] hi_val, lo_val, mdu_op2;
  logic [31:0]       mdu_pc4;

  logic              valid_q, valid_d, pcsrc_q, pcsrc_d;
  logic [DATA_W-1:0] res_q, res_d, op2_q, op2_d;
  logic [31:0]       npc_q, npc_d;

  assign func    = bus.i_imm[5:0];
  assign shamt   = bus.i_imm[10:6];
  assign imm_ext = bus.i_extOp ? DATA_W'($signed(bus.i_imm[15:0])) : DATA_W'(bus.i_imm[15:0]);
  assign op_b    = bus.i_ALUSrc_op2 ? imm_ext : bus.i_op2;
  assign pc4     = bus.i_pc + 32'd4;
  assign br_tgt  = pc4 + {{14{bus.i_imm[15]}}, bus.i_imm[15:0], 2'b00};
  assign j_tgt   = {pc4[31:28], bus.i_imm, 2'b00};
  assign zero    = (bus.i_op1 == op_b);
  assign pcsrc   = (bus.i_beq && zero) || (bus.i_bne && !zero) || bus.i_jump;
  assign next_pc = bus.i_jump ? j_tgt : (pcsrc ? br_tgt : pc4);

  // Flush wins over a same-cycle accept so the instruction is dropped.
  assign bus.o_ready = i_rst_n && mdu_idle && (!valid_q || bus.i_ready);
  assign accept      = bus.i_valid && bus.o_ready && !bus.i_flush;

  // ALU: R-type (ALUop 0) decodes func; other ALUop values are the I-type opcode.
  always_comb begin
    alu = '0;
    if (bus.i_ALUop == OP_RTYPE) begin
      case (func)
        6'h20, 6'h21: alu = bus.i_op1 + op_b;
        6'h22, 6'h23: alu = bus.i_op1 - op_b;
        6'h24:        alu = bus.i_op1 & op_b;
        6'h25:        alu = bus.i_op1 | op_b;
        6'h26:        alu = bus.i_op1 ^ op_b;
        6'h27:        alu = ~(bus.i_op1 | op_b);
        6'h2A:        alu = {{(DATA_W-1){1'b0}}, ($signed(bus.i_op1) < $signed(op_b))};
        6'h2B:        alu = {{(DATA_W-1){1'b0}}, (bus.i_op1 < op_b)};
        6'h00:        alu = op_b << shamt;
        6'h02:        alu = op_b >> shamt;
        6'h03:        alu = DATA_W'($signed(op_b) >>> shamt);
        F_MFHI:       alu = hi_val;
        F_MFLO:       alu = lo_val;
        default:      alu = '0;
      endcase
    end else begin
      case (bus.i_ALUop)
        6'h04, 6'h05: alu = bus.i_op1 - op_b;
        6'h0A:        alu = {{(DATA_W-1){1'b0}}, ($signed(bus.i_op1) < $signed(op_b))};
        6'h0B:        alu = {{(DATA_W-1){1'b0}}, (bus.i_op1 < op_b)};
        6'h0C:        alu = bus.i_op1 & op_b;
        6'h0D:        alu = bus.i_op1 | op_b;
        6'h0E:        alu = bus.i_op1 ^ op_b;
        6'h0F:        alu = op_b << 16;
        default:      alu = bus.i_op1 + op_b;
      endcase
    end
  end

  // Result register: load on accept or MDU completion, hold under backpressure, drop on flush.
  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    op2_d   = op2_q;
    npc_d   = npc_q;
    pcsrc_d = pcsrc_q;
    if (bus.i_flush) begin
      valid_d = 1'b0;
    end else if (mdu_done) begin
      valid_d = 1'b1;
      res_d   = '0;
      op2_d   = mdu_op2;
      npc_d   = mdu_pc4;
      pcsrc_d = 1'b0;
    end else if (accept) begin
      valid_d = !is_mdu;
      if (!is_mdu) begin
        res_d   = alu;
        op2_d   = bus.i_op2;
        npc_d   = next_pc;
        pcsrc_d = pcsrc;
      end
    end else if (bus.i_ready) begin
      valid_d = 1'b0;
    end
  end

  // Result register state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      op2_q   <= '0;
      npc_q   <= '0;
      pcsrc_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      op2_q   <= op2_d;
      npc_q   <= npc_d;
      pcsrc_q <= pcsrc_d;
    end
  end

  assign bus.o_valid  = valid_q;
  assign bus.o_ALUres = res_q;
  assign bus.o_op2    = op2_q;
  assign bus.o_nextPC = npc_q;
  assign bus.o_pcsrc  = pcsrc_q;

`ifdef EXECUTE_PIPE_MDU_EN
  localparam int N_ITER = DATA_W / MDU_ITER;
  localparam int CNT_W  = $clog2(N_ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // rem: mul = running high half plus carry; div = partial remainder.
  // acc: mul = multiplier shifting out / product low; div = dividend in, quotient out.
  logic [DATA_W:0]     rem_q, rem_d, st_hi;
  logic [DATA_W-1:0]   acc_q, acc_d, st_lo;
  logic [DATA_W-1:0]   opb_q, opb_d, opa_q, opa_d, hi_q, hi_d, lo_q, lo_d, mop2_q, mop2_d;
  logic [31:0]         mpc_q, mpc_d;
  logic                qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, isdiv_q, isdiv_d;
  logic                is_div, is_signed, sa, sb;
  logic [DATA_W-1:0]   mag_a, mag_b, quo, rmd;
  logic [2*DATA_W-1:0] prod;

  // MULT=18 MULTU=19 DIV=1A DIVU=1B: bit1 selects divide, bit0 selects unsigned.
  assign is_mdu    = (bus.i_ALUop == OP_RTYPE) && (func[5:2] == 4'b0110);
  assign is_div    = func[1];
  assign is_signed = !func[0];
  assign sa        = is_signed && bus.i_op1[DATA_W-1];
  assign sb        = is_signed && op_b[DATA_W-1];
  assign mag_a     = sa ? -bus.i_op1 : bus.i_op1;
  assign mag_b     = sb ? -op_b : op_b;

  // MDU next state: shift-add multiply / restoring divide on magnitudes, signs fixed in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    opa_d   = opa_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mop2_d  = mop2_q;
    mpc_d   = mpc_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    isdiv_d = isdiv_q;
    st_hi   = rem_q;
    st_lo   = acc_q;
    for (int k = 0; k < MDU_ITER; k++) begin
      if (state_q == S_MUL) begin
        if (st_lo[0]) st_hi = st_hi + {1'b0, opb_q};
        {st_hi, st_lo} = {st_hi, st_lo} >> 1;
      end else begin
        {st_hi, st_lo} = {st_hi[DATA_W-1:0], st_lo, 1'b0};
        if (st_hi >= {1'b0, opb_q}) begin
          st_hi    = st_hi - {1'b0, opb_q};
          st_lo[0] = 1'b1;
        end
      end
    end
    prod = {rem_q[DATA_W-1:0], acc_q};
    if (qneg_q) prod = -prod;
    quo  = qneg_q ? -acc_q : acc_q;
    rmd  = rneg_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
    case (state_q)
      S_IDLE: begin
        if (accept && is_mdu) begin
          state_d = is_div ? S_DIV : S_MUL;
          cnt_d   = CNT_W'(N_ITER);
          rem_d   = '0;
          acc_d   = mag_a;
          opb_d   = mag_b;
          opa_d   = bus.i_op1;
          qneg_d  = sa ^ sb;
          rneg_d  = sa;
          dz_d    = (op_b == '0);
          isdiv_d = is_div;
          mop2_d  = bus.i_op2;
          mpc_d   = pc4;
        end
      end
      S_MUL, S_DIV: begin
        rem_d = st_hi;
        acc_d = st_lo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        if (!isdiv_q) begin
          hi_d = prod[2*DATA_W-1:DATA_W];
          lo_d = prod[DATA_W-1:0];
        end else if (dz_q) begin
          hi_d = opa_q;
          lo_d = '1;
        end else begin
          hi_d = rmd;
          lo_d = quo;
        end
      end
    endcase
    if (bus.i_flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // MDU FSM and datapath state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      opa_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mop2_q  <= '0;
      mpc_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      isdiv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      opa_q   <= opa_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mop2_q  <= mop2_d;
      mpc_q   <= mpc_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      isdiv_q <= isdiv_d;
    end
  end

  assign mdu_idle   = (state_q == S_IDLE);
  assign mdu_done   = (state_q == S_DONE);
  assign hi_val     = hi_q;
  assign lo_val     = lo_q;
  assign mdu_op2    = mop2_q;
  assign mdu_pc4    = mpc_q;
  assign bus.o_busy = !mdu_idle;
`else
  // No MDU: MULT/DIV/MFHI/MFLO fall through the single-cycle path with a zero result.
  assign is_mdu     = 1'b0;
  assign mdu_idle   = 1'b1;
  assign mdu_done   = 1'b0;
  assign hi_val     = '0;
  assign lo_val     = '0;
  assign mdu_op2    = '0;
  assign mdu_pc4    = '0;
  assign bus.o_busy = 1'b0;
`endif
endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: ALU ops, branches/jumps, backpressure, flush and (when built in) MUL/DIV.
// Latency: checks 1-cycle results and MDU completion timing.
// Backpressure: exercises i_ready low with a pending instruction.
module tb_execute_pipe;
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_SRC  = 5'b10000;
  localparam logic [4:0] C_EXT  = 5'b01000;
  localparam logic [4:0] C_BEQ  = 5'b00100;
  localparam logic [4:0] C_BNE  = 5'b00010;
  localparam logic [4:0] C_JMP  = 5'b00001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  execute_pipe_if #(.DATA_W(32)) bus ();
  execute_pipe #(.DATA_W(32), .MDU_ITER(1)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_instr(input logic [5:0] aluop, input logic [25:0] imm, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] ctl, input logic [31:0] pc);
    bus.i_ALUop       = aluop;
    bus.i_imm         = imm;
    bus.i_op1         = a;
    bus.i_op2         = b;
    bus.i_ALUSrc_op2  = ctl[4];
    bus.i_extOp       = ctl[3];
    bus.i_beq         = ctl[2];
    bus.i_bne         = ctl[1];
    bus.i_jump        = ctl[0];
    bus.i_pc          = pc;
  endtask

  // Present an instruction, wait (bounded) for acceptance, return at the negedge after acceptance.
  task automatic issue(input logic [5:0] aluop, input logic [25:0] imm, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] ctl, input logic [31:0] pc);
    bit done;
    done = 1'b0;
    set_instr(aluop, imm, a, b, ctl, pc);
    bus.i_valid = 1'b1;
    #1;
    for (int k = 0; k < 200; k++) begin
      if (bus.o_ready) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) check("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic rtype(input logic [25:0] imm, input logic [31:0] a, input logic [31:0] b);
    issue(6'h00, imm, a, b, C_NONE, 32'h0);
  endtask

  task automatic wait_mdu(output int low_cycles);
    low_cycles = 0;
    while (!bus.o_ready && low_cycles < 200) begin
      low_cycles++;
      @(negedge clk);
    end
    if (low_cycles >= 200) check("mdu_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int cyc;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_flush = 1'b0;
    set_instr(6'h00, 26'h0, 32'h0, 32'h0, C_NONE, 32'h0);

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_res", bus.o_ALUres, 32'h0);
    check("rst_op2", bus.o_op2, 32'h0);
    check("rst_npc", bus.o_nextPC, 32'h0);
    check("rst_pcsrc", bus.o_pcsrc, 1'b0);
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_ready", bus.o_ready, 1'b0);
    rst_n = 1'b1;
    #1 check("post_rst_ready", bus.o_ready, 1'b1);

    // ALU
    issue(6'h00, 26'h20, 32'd5, 32'd7, C_NONE, 32'h40);
    check("add_valid", bus.o_valid, 1'b1);
    check("add_res", bus.o_ALUres, 32'd12);
    check("add_op2", bus.o_op2, 32'd7);
    check("add_npc", bus.o_nextPC, 32'h44);
    rtype(26'h22, 32'd3, 32'd5);                       check("sub", bus.o_ALUres, 32'hFFFF_FFFE);
    issue(6'h08, 26'hFFFF, 32'd10, 32'd0, C_SRC | C_EXT, 32'h0);
    check("addi_sext", bus.o_ALUres, 32'd9);
    issue(6'h0D, 26'h8001, 32'h0F00, 32'd0, C_SRC, 32'h0);
    check("ori_zext", bus.o_ALUres, 32'h8F01);
    rtype(26'h2A, 32'hFFFF_FFFF, 32'd1);              check("slt", bus.o_ALUres, 32'd1);
    rtype(26'h2B, 32'hFFFF_FFFF, 32'd1);              check("sltu", bus.o_ALUres, 32'd0);
    rtype(26'h103, 32'd0, 32'h8000_0000);             check("sra4", bus.o_ALUres, 32'hF800_0000);
    rtype(26'h102, 32'd0, 32'h8000_0000);             check("srl4", bus.o_ALUres, 32'h0800_0000);
    issue(6'h0F, 26'h1234, 32'd0, 32'd0, C_SRC, 32'h0);
    check("lui", bus.o_ALUres, 32'h1234_0000);
    rtype(26'h27, 32'h0F0F_0000, 32'h0000_00FF);      check("nor", bus.o_ALUres, 32'hF0F0_FF00);

    // Branches and jump
    issue(6'h04, 26'h0004, 32'd3, 32'd3, C_BEQ, 32'h100);
    check("beq_t_pcsrc", bus.o_pcsrc, 1'b1);
    check("beq_t_npc", bus.o_nextPC, 32'h114);
    issue(6'h04, 26'h0004, 32'd3, 32'd4, C_BEQ, 32'h100);
    check("beq_nt_pcsrc", bus.o_pcsrc, 1'b0);
    check("beq_nt_npc", bus.o_nextPC, 32'h104);
    issue(6'h05, 26'hFFFE, 32'd1, 32'd2, C_BNE, 32'h200);
    check("bne_back_pcsrc", bus.o_pcsrc, 1'b1);
    check("bne_back_npc", bus.o_nextPC, 32'h1FC);
    issue(6'h02, 26'h0000040, 32'd0, 32'd0, C_JMP, 32'h1000_0000);
    check("j_pcsrc", bus.o_pcsrc, 1'b1);
    check("j_npc", bus.o_nextPC, 32'h1000_0100);

    // Backpressure: result held 3 cycles, next instruction waits then is accepted
    @(negedge clk);
    bus.i_ready = 1'b0;
    rtype(26'h20, 32'd1, 32'd2);
    set_instr(6'h00, 26'h20, 32'd10, 32'd20, C_NONE, 32'h0);
    bus.i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_valid", bus.o_valid, 1'b1);
      check("bp_res", bus.o_ALUres, 32'd3);
      check("bp_op2", bus.o_op2, 32'd2);
      check("bp_ready", bus.o_ready, 1'b0);
      @(negedge clk);
    end
    bus.i_ready = 1'b1;
    #1 check("bp_release_ready", bus.o_ready, 1'b1);
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", bus.o_valid, 1'b1);
    check("bp_next_res", bus.o_ALUres, 32'd30);

    // Flush clears a held result and drops the instruction offered in the same cycle
    @(negedge clk);
    bus.i_ready = 1'b0;
    rtype(26'h20, 32'd4, 32'd4);
    check("pre_flush_res", bus.o_ALUres, 32'd8);
    set_instr(6'h00, 26'h20, 32'd9, 32'd9, C_NONE, 32'h0);
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", bus.o_valid, 1'b0);
    @(negedge clk);
    check("flush_dropped", bus.o_valid, 1'b0);

`ifdef EXECUTE_PIPE_MDU_EN
    // MULTU 0xFFFFFFFF * 2
    rtype(26'h19, 32'hFFFF_FFFF, 32'd2);
    check("multu_busy", bus.o_busy, 1'b1);
    check("multu_ready_low", bus.o_ready, 1'b0);
    wait_mdu(cyc);
    check("multu_latency", (cyc >= 32 && cyc <= 33), 1'b1);
    check("multu_done_valid", bus.o_valid, 1'b1);
    check("multu_done_res", bus.o_ALUres, 32'h0);
    check("multu_done_pcsrc", bus.o_pcsrc, 1'b0);
    rtype(26'h10, 32'd0, 32'd0);                      check("multu_hi", bus.o_ALUres, 32'h1);
    rtype(26'h12, 32'd0, 32'd0);                      check("multu_lo", bus.o_ALUres, 32'hFFFF_FFFE);

    // MULT -3 * 5
    rtype(26'h18, 32'hFFFF_FFFD, 32'd5);
    wait_mdu(cyc);
    rtype(26'h10, 32'd0, 32'd0);                      check("mult_hi", bus.o_ALUres, 32'hFFFF_FFFF);
    rtype(26'h12, 32'd0, 32'd0);                      check("mult_lo", bus.o_ALUres, 32'hFFFF_FFF1);

    // DIV -7 / 2
    rtype(26'h1A, 32'hFFFF_FFF9, 32'd2);
    wait_mdu(cyc);
    rtype(26'h12, 32'd0, 32'd0);                      check("div_lo", bus.o_ALUres, 32'hFFFF_FFFD);
    rtype(26'h10, 32'd0, 32'd0);                      check("div_hi", bus.o_ALUres, 32'hFFFF_FFFF);

    // DIVU 9 / 0
    rtype(26'h1B, 32'd9, 32'd0);
    wait_mdu(cyc);
    check("divu0_latency", (cyc >= 32 && cyc <= 33), 1'b1);
    rtype(26'h12, 32'd0, 32'd0);                      check("divu0_lo", bus.o_ALUres, 32'hFFFF_FFFF);
    rtype(26'h10, 32'd0, 32'd0);                      check("divu0_hi", bus.o_ALUres, 32'd9);

    // Flush at cycle 10 of a DIVU: aborted, HI/LO keep the 9/0 result
    rtype(26'h1B, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1 bus.i_flush = 1'b0;
    @(negedge clk);
    check("mdu_flush_valid", bus.o_valid, 1'b0);
    check("mdu_flush_ready", bus.o_ready, 1'b1);
    check("mdu_flush_busy", bus.o_busy, 1'b0);
    rtype(26'h10, 32'd0, 32'd0);                      check("mdu_flush_hi", bus.o_ALUres, 32'd9);
    rtype(26'h12, 32'd0, 32'd0);                      check("mdu_flush_lo", bus.o_ALUres, 32'hFFFF_FFFF);
`else
    // Without the MDU, multiply/divide and HI/LO moves retire in one cycle with zero
    rtype(26'h18, 32'd3, 32'd5);
    check("nomdu_mult_valid", bus.o_valid, 1'b1);
    check("nomdu_mult_res", bus.o_ALUres, 32'h0);
    check("nomdu_busy", bus.o_busy, 1'b0);
    rtype(26'h1A, 32'd9, 32'd3);                      check("nomdu_div_res", bus.o_ALUres, 32'h0);
    rtype(26'h12, 32'd0, 32'd0);                      check("nomdu_mflo", bus.o_ALUres, 32'h0);
    cyc = 0;
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
